// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: signed int32 -> IEEE-754 single, one op in flight.
// Optional I2F_FAST_NORM_EN: single-cycle normalise via priority encoder.
`timescale 1ns/1ps
module int_to_fp_converter #(
  parameter bit TRUNCATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;

  logic        accept;
  logic        in_zero;
  logic [31:0] in_mag;

  logic [22:0] frac;
  logic        g_bit;
  logic        s_bit;
  logic        rnd_up;
  logic        carry;
  logic [22:0] frac_r;
  logic [7:0]  exp_r;

  assign accept  = in_valid && in_ready;
  assign in_zero = (in_data == 32'h0);
  assign in_mag  = in_data[31] ? (32'h0 - in_data) : in_data;

`ifdef I2F_FAST_NORM_EN
  logic [4:0]  lz;
  logic [31:0] mag_sh;
  logic [7:0]  exp_sh;

  // Leading-zero count; the highest set bit wins.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_q[i]) lz = 5'(31 - i);
    end
  end

  assign mag_sh = mag_q << lz;
  assign exp_sh = 8'd158 - {3'b000, lz};
`endif

  // Round-to-nearest-even on guard/sticky, carry bumps the exponent.
  always_comb begin
    frac   = mag_q[30:8];
    g_bit  = mag_q[7];
    s_bit  = |mag_q[6:0];
    rnd_up = !TRUNCATE && g_bit && (s_bit || frac[0]);
    {carry, frac_r} = {1'b0, frac} + 24'(rnd_up);
    exp_r  = exp_q + 8'(carry);
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = in_zero ? DONE : NORM;
      end
      NORM: begin
`ifdef I2F_FAST_NORM_EN
        state_nx = ROUND;
`else
        if (mag_q[31]) state_nx = ROUND;
`endif
      end
      ROUND: state_nx = DONE;
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      sign_q    <= 1'b0;
      mag_q     <= 32'h0;
      exp_q     <= 8'h0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= in_data[31];
            mag_q  <= in_mag;
            exp_q  <= 8'd158;
            if (in_zero) out_data <= 32'h0;
          end
        end
        NORM: begin
`ifdef I2F_FAST_NORM_EN
          mag_q <= mag_sh;
          exp_q <= exp_sh;
`else
          if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
`endif
        end
        ROUND: out_data <= {sign_q, exp_r, frac_r};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb_int_to_fp_converter: random + directed int->float checks
// against an arithmetic reference, for both rounding modes.
`timescale 1ns/1ps
module tb_int_to_fp_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    int          lat;
  } exp_t;

  exp_t q[$];

`ifdef I2F_FAST_NORM_EN
  localparam int RST_WAIT = 0;
  localparam bit FAST = 1'b1;
`else
  localparam int RST_WAIT = 10;
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  int_to_fp_converter #(.TRUNCATE(1'b0)) u_rne (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0)
  );

  int_to_fp_converter #(.TRUNCATE(1'b1)) u_trz (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1)
  );

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic longint absval(logic [31:0] x);
    if (x[31]) return 64'sd4294967296 - longint'(x);
    return longint'(x);
  endfunction

  function automatic int msb(longint m);
    int p = 0;
    for (int i = 0; i < 33; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Reference: value = m * 2^0, scaled to 24 significant bits.
  function automatic logic [31:0] model(logic [31:0] x, bit trunc);
    longint m, kept, rem, half;
    int p, e, r;
    if (x == 32'h0) return 32'h0;
    m = absval(x);
    p = msb(m);
    e = 127 + p;
    if (p <= 23) begin
      kept = m << (23 - p);
    end else begin
      r    = p - 23;
      kept = m >> r;
      rem  = m & ((64'sd1 << r) - 1);
      half = 64'sd1 << (r - 1);
      if (!trunc && (rem > half || (rem == half && kept[0])))
        kept++;
      if (kept == (64'sd1 << 24)) begin
        kept = kept >> 1;
        e++;
      end
    end
    return {x[31], 8'(e), kept[22:0]};
  endfunction

  function automatic int exp_lat(logic [31:0] x);
    if (x == 32'h0) return 1;
    if (FAST) return 3;
    return (31 - msb(absval(x))) + 3;
  endfunction

  // Compare process: checks both DUTs whenever a result is pending.
  int since = 0;
  bit pending = 0;
  bit seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      since = 0;
    end else begin
      if (pending) begin
        since++;
        if (out_valid0 || out_valid1) begin
          if (q.size() == 0) begin
            chk("no_expect", 32'd1, 32'd0);
            pending = 0;
          end else begin
            if (!seen) begin
              chk("latency", 32'(since), 32'(q[0].lat));
              seen = 1;
            end
            chk("data_rne", out_data0, q[0].e0);
            chk("data_trz", out_data1, q[0].e1);
            chk("valid_pair", {31'd0, out_valid0 & out_valid1},
                32'd1);
            chk("ready_busy", {30'd0, in_ready0, in_ready1}, 32'd0);
            if (out_ready) begin
              void'(q.pop_front());
              pending = 0;
            end
          end
        end else begin
          chk("ready_busy", {30'd0, in_ready0, in_ready1}, 32'd0);
          if (q.size() > 0 && since > q[0].lat) begin
            chk("latency_overrun", 32'(since), 32'(q[0].lat));
            pending = 0;
          end
        end
      end else if (out_valid0 || out_valid1) begin
        chk("spurious_valid", {30'd0, out_valid0, out_valid1},
            32'd0);
      end
      if (in_valid && in_ready0) begin
        pending = 1;
        since = 0;
        seen = 0;
      end
    end
  end

  task automatic send(input logic [31:0] x);
    int n = 0;
    in_data = x;
    in_valid = 1'b1;
    while (!in_ready0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic convert(input logic [31:0] x,
                         input logic [31:0] e0,
                         input logic [31:0] e1,
                         input int hold,
                         input bit poke);
    exp_t t;
    int n = 0;
    t.e0 = e0;
    t.e1 = e1;
    t.lat = exp_lat(x);
    q.push_back(t);
    send(x);
    if (poke) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    while (!out_valid0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("valid_timeout", 32'd0, 32'd1);
      q.delete();
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] dx [8];
  logic [31:0] d0 [8];
  logic [31:0] d1 [8];

  initial begin
    dx = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
           32'h7FFF_FFFF, 32'd16777217, 32'd16777219, 32'd5};
    d0 = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'hCF00_0000,
           32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002,
           32'h40A0_0000};
    d1 = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'hCF00_0000,
           32'h4EFF_FFFF, 32'h4B80_0000, 32'h4B80_0001,
           32'h40A0_0000};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
    chk("rst_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
    chk("rst_data0", out_data0, 32'h0);
    chk("rst_data1", out_data1, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", {30'd0, in_ready0, in_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("ready_post_edge", {30'd0, in_ready0, in_ready1}, 32'd3);

    for (int i = 0; i < 8; i++)
      convert(dx[i], d0[i], d1[i], (i == 1) ? 5 : i % 3, i == 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x;
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = 32'h0 - x;
      convert(x, model(x, 1'b0), model(x, 1'b1),
              $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    convert(32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 0, 0);
    q.push_back('{32'h3F80_0000, 32'h3F80_0000, exp_lat(32'd1)});
    send(32'd1);
    repeat (RST_WAIT) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
    chk("abort_data0", out_data0, 32'h0);
    chk("abort_data1", out_data1, 32'h0);
    chk("abort_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
    convert(32'd5, 32'h40A0_0000, 32'h40A0_0000, 1, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
